ring_sequence_monitor: RTL and testbench
========================================

# ring_sequence_monitor

Downstream checker for the one-hot ring counter. It samples the counter's `count` bus every clock and confirms that the value is one-hot and advances by exactly one rotate-left step per cycle. It declares lock after a programmable run of correct steps, counts full revolutions while locked, and raises a sticky, coded fault on any illegal value or step.

## Interface
- `WIDTH`, 4: ring length; width of `phase`; must be ≥ 2.
- `LOCK_CNT`, 2: consecutive correct steps required to enter LOCKED; must be ≥ 1.
- `REV_W`, 16: width of the revolution counter.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `phase`  in  WIDTH  ring counter output (`count`), sampled every clock.
- `clear`  in  1  synchronous; returns the FSM to SEARCH, clears fault and `rev_count`.
- `locked`  out  1  high while in LOCKED.
- `fault`  out  1  high while in FAULT; sticky.
- `fault_code`  out  2  00 none, 01 not one-hot (includes all-zero), 10 wrong step.
- `rev_count`  out  REV_W  completed revolutions while locked; saturates at all-ones.
- `phase_idx`  out  clog2(WIDTH)  binary index of the last one-hot `phase` sampled.

## Operation
- `prev` register holds the previous sample of `phase`. It loads every cycle; its reset value is 0.
- `onehot` = exactly one bit of `phase` set.
- `step_ok` = `onehot` and `phase == rotl(prev)`. Under rotl, bit i moves to i+1 and bit WIDTH-1 wraps to bit 0.
- FSM states: SEARCH, ACQUIRE, LOCKED, FAULT. Reset state is SEARCH.
- SEARCH: `onehot` → ACQUIRE with `good_cnt` = 0; otherwise stay.
- ACQUIRE: on `step_ok`, `good_cnt`++. When the incremented value equals LOCK_CNT → LOCKED. On not `step_ok` → SEARCH; no fault is raised and `good_cnt` = 0.
- LOCKED: on `step_ok`, stay. On not `step_ok` → FAULT. Latch `fault_code` = 01 if not `onehot`, else 10; not-one-hot has priority.
- FAULT: hold, including `fault_code`, regardless of `phase`. Leave only on `clear` or `reset`.
- `clear` (any state) → SEARCH next cycle. It zeroes `good_cnt`, `rev_count` and `fault_code`. `clear` wins over any simultaneous transition, including a fault detected in the same cycle.
- `rev_count`: increments when state is LOCKED, `step_ok` is true and `phase[0]` = 1 (wrap completed). It holds at 2^REV_W−1.
- `phase_idx`: loads the encoded index whenever `onehot`; otherwise holds.
- A ring counter reset mid-run while LOCKED produces an out-of-sequence value and must fault with code 10. An all-zero value must fault with code 01.

## Timing
- All outputs are registered. Reset values: `locked`=0, `fault`=0, `fault_code`=00, `rev_count`=0, `phase_idx`=0.
- Lock latency with LOCK_CNT=2, starting from SEARCH:
  - edge 1 samples a one-hot value → ACQUIRE.
  - edges 2 and 3 sample correct steps → `locked`=1 after edge 3.
- Fault latency: `fault`, `fault_code` and `locked`=0 are valid after the edge that samples the bad value.
- `rev_count` updates on the same edge that samples the wrapping value.
- Asynchronous reset takes effect immediately. It clears all state, including `prev`.

## Structure
- Package `ring_mon_pkg` holds:
  - state enum `ring_mon_state_t` (SEARCH, ACQUIRE, LOCKED, FAULT).
  - fault-code constants FC_NONE=2'b00, FC_ONEHOT=2'b01, FC_STEP=2'b10.
- Sub-module `ring_onehot_decode` (combinational, parameterised on WIDTH): outputs `onehot` and binary `idx`. It is reused by any future ring consumers.
- The top level holds the FSM, `prev`, `good_cnt` (clog2(LOCK_CNT+1) bits) and the saturating `rev_count`.

## Test plan
- Reset low, then drive 0001,0010,0100,1000,0001,… → `locked`=1 after the 3rd sample. `rev_count`=1 after the sample of 0001 that follows 1000. `phase_idx` tracks 0,1,2,3.
- While locked, drive 0101 → `fault`=1, `fault_code`=01, `locked`=0. Resume a legal sequence → outputs hold unchanged.
- While locked at 0100, jump to 0001 (ring reset) → `fault_code`=10. Pulse `clear` → SEARCH, `rev_count`=0, relock after 3 legal samples.
- In ACQUIRE, drive 0010 then 1000 → return to SEARCH, `fault`=0, `locked`=0.
- Assert `clear` in the same cycle as an illegal sample in LOCKED → state SEARCH, `fault`=0.
- With REV_W=2, run 5 revolutions locked → `rev_count` stops at 3. Assert `reset` mid-cycle → all outputs 0 immediately.

Source files
------------

// File: rtl/ring_mon_pkg.sv
// Shared types and fault codes for ring-counter consumers.
package ring_mon_pkg;
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } ring_mon_state_t;

  localparam logic [1:0] FC_NONE   = 2'b00;
  localparam logic [1:0] FC_ONEHOT = 2'b01;
  localparam logic [1:0] FC_STEP   = 2'b10;
endpackage

// File: rtl/ring_onehot_decode.sv
// Combinational one-hot check and binary index encoder for a ring value.
module ring_onehot_decode #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         value,
  output logic                     onehot,
  output logic [$clog2(WIDTH)-1:0] idx
);
  logic [$clog2(WIDTH+1)-1:0] ones;

  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) begin
        ones = ones + 1'b1;
        idx  = idx | ($clog2(WIDTH))'(i);
      end
    end
    onehot = (ones == 1);
  end
endmodule

// File: rtl/ring_sequence_monitor.sv
// Checks that a one-hot ring counter rotates left by one step each cycle,
// locks after LOCK_CNT good steps, counts revolutions and latches faults.
module ring_sequence_monitor
  import ring_mon_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int REV_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         phase,
  input  logic                     clear,
  output logic                     locked,
  output logic                     fault,
  output logic [1:0]               fault_code,
  output logic [REV_W-1:0]         rev_count,
  output logic [$clog2(WIDTH)-1:0] phase_idx
);
  localparam int IW = $clog2(WIDTH);
  localparam int GW = $clog2(LOCK_CNT + 1);

  ring_mon_state_t  state, state_nxt;
  logic [WIDTH-1:0] prev;
  logic [GW-1:0]    good_cnt, good_nxt, good_inc;
  logic [1:0]       code_nxt;
  logic             onehot, step_ok, rev_inc;
  logic [IW-1:0]    idx;

  ring_onehot_decode #(.WIDTH(WIDTH)) u_dec (
    .value  (phase),
    .onehot (onehot),
    .idx    (idx)
  );

  assign step_ok  = onehot && (phase == {prev[WIDTH-2:0], prev[WIDTH-1]});
  assign good_inc = good_cnt + 1'b1;
  // Revolution boundary: a correct step landing back on bit 0.
  assign rev_inc  = (state == LOCKED) && step_ok && phase[0] && (rev_count != '1);

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    code_nxt  = fault_code;
    case (state)
      SEARCH: if (onehot) begin
        state_nxt = ACQUIRE;
        good_nxt  = '0;
      end
      ACQUIRE: if (step_ok) begin
        good_nxt = good_inc;
        if (good_inc == GW'(LOCK_CNT)) state_nxt = LOCKED;
      end else begin
        state_nxt = SEARCH;
        good_nxt  = '0;
      end
      LOCKED: if (!step_ok) begin
        state_nxt = FAULT;
        code_nxt  = onehot ? FC_STEP : FC_ONEHOT;
      end
      default: ;
    endcase
    if (clear) begin
      state_nxt = SEARCH;
      good_nxt  = '0;
      code_nxt  = FC_NONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SEARCH;
      prev       <= '0;
      good_cnt   <= '0;
      fault_code <= FC_NONE;
      rev_count  <= '0;
      phase_idx  <= '0;
      locked     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev       <= phase;
      good_cnt   <= good_nxt;
      fault_code <= code_nxt;
      locked     <= (state_nxt == LOCKED);
      fault      <= (state_nxt == FAULT);
      if (onehot) phase_idx <= idx;
      if (clear)        rev_count <= '0;
      else if (rev_inc) rev_count <= rev_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_ring_sequence_monitor.sv
// Directed-vector scoreboard bench for ring_sequence_monitor (REV_W=2 to reach saturation).
module tb_ring_sequence_monitor;
  typedef struct packed {
    logic       locked;
    logic       fault;
    logic [1:0] code;
    logic [1:0] rev;
    logic [1:0] idx;
  } exp_t;

  logic       clk = 0;
  logic       reset = 0;
  logic [3:0] phase = '0;
  logic       clear = 0;
  logic       locked, fault;
  logic [1:0] fault_code, rev_count, phase_idx;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  ring_sequence_monitor #(.WIDTH(4), .LOCK_CNT(2), .REV_W(2)) dut (
    .clk(clk), .reset(reset), .phase(phase), .clear(clear),
    .locked(locked), .fault(fault), .fault_code(fault_code),
    .rev_count(rev_count), .phase_idx(phase_idx)
  );

  always #5 clk = ~clk;

  function automatic exp_t actual();
    exp_t a;
    a.locked = locked; a.fault = fault; a.code = fault_code;
    a.rev = rev_count; a.idx = phase_idx;
    return a;
  endfunction

  task automatic check(input string name, input exp_t exp);
    exp_t act;
    act = actual();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got L=%b F=%b code=%b rev=%0d idx=%0d, want L=%b F=%b code=%b rev=%0d idx=%0d",
               name, act.locked, act.fault, act.code, act.rev, act.idx,
               exp.locked, exp.fault, exp.code, exp.rev, exp.idx);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare just after each edge.
  int vec_no = 0;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      vec_no++;
      check($sformatf("vec%0d", vec_no), q.pop_front());
    end
  end

  task automatic v(input logic [3:0] p, input logic c, input logic l, input logic f,
                   input logic [1:0] code, input logic [1:0] rev, input logic [1:0] idx);
    @(negedge clk);
    phase = p;
    clear = c;
    q.push_back('{locked: l, fault: f, code: code, rev: rev, idx: idx});
  endtask

  // One locked revolution 0010,0100,1000,0001 ending at rev count r.
  task automatic rev4(input logic [1:0] r_before, input logic [1:0] r_after);
    v(4'b0010, 0, 1, 0, 2'b00, r_before, 2'd1);
    v(4'b0100, 0, 1, 0, 2'b00, r_before, 2'd2);
    v(4'b1000, 0, 1, 0, 2'b00, r_before, 2'd3);
    v(4'b0001, 0, 1, 0, 2'b00, r_after,  2'd0);
  endtask

  initial begin
    #12;
    check("reset_state", '0);
    @(negedge clk);
    reset = 1;

    // Lock sequence
    v(4'b0001, 0, 0, 0, 2'b00, 2'd0, 2'd0);
    v(4'b0010, 0, 0, 0, 2'b00, 2'd0, 2'd1);
    v(4'b0100, 0, 1, 0, 2'b00, 2'd0, 2'd2);
    v(4'b1000, 0, 1, 0, 2'b00, 2'd0, 2'd3);
    v(4'b0001, 0, 1, 0, 2'b00, 2'd1, 2'd0);
    v(4'b0010, 0, 1, 0, 2'b00, 2'd1, 2'd1);
    // Not one-hot while locked, then sticky fault during legal values
    v(4'b0101, 0, 0, 1, 2'b01, 2'd1, 2'd1);
    v(4'b0100, 0, 0, 1, 2'b01, 2'd1, 2'd2);
    v(4'b1000, 0, 0, 1, 2'b01, 2'd1, 2'd3);
    v(4'b0001, 1, 0, 0, 2'b00, 2'd0, 2'd0);
    // Relock, then ring reset jump 0100 -> 0001
    v(4'b0010, 0, 0, 0, 2'b00, 2'd0, 2'd1);
    v(4'b0100, 0, 0, 0, 2'b00, 2'd0, 2'd2);
    v(4'b1000, 0, 1, 0, 2'b00, 2'd0, 2'd3);
    v(4'b0001, 0, 1, 0, 2'b00, 2'd1, 2'd0);
    v(4'b0010, 0, 1, 0, 2'b00, 2'd1, 2'd1);
    v(4'b0100, 0, 1, 0, 2'b00, 2'd1, 2'd2);
    v(4'b0001, 0, 0, 1, 2'b10, 2'd1, 2'd0);
    v(4'b0001, 1, 0, 0, 2'b00, 2'd0, 2'd0);
    v(4'b0010, 0, 0, 0, 2'b00, 2'd0, 2'd1);
    v(4'b0100, 0, 0, 0, 2'b00, 2'd0, 2'd2);
    v(4'b1000, 0, 1, 0, 2'b00, 2'd0, 2'd3);
    // Broken step in ACQUIRE returns to SEARCH without fault
    v(4'b0001, 1, 0, 0, 2'b00, 2'd0, 2'd0);
    v(4'b0010, 0, 0, 0, 2'b00, 2'd0, 2'd1);
    v(4'b1000, 0, 0, 0, 2'b00, 2'd0, 2'd3);
    v(4'b0001, 0, 0, 0, 2'b00, 2'd0, 2'd0);
    v(4'b0010, 0, 0, 0, 2'b00, 2'd0, 2'd1);
    v(4'b0100, 0, 1, 0, 2'b00, 2'd0, 2'd2);
    // clear beats an illegal sample while locked
    v(4'b0000, 1, 0, 0, 2'b00, 2'd0, 2'd2);
    v(4'b0000, 0, 0, 0, 2'b00, 2'd0, 2'd2);
    // Lock and run 5 revolutions: counter saturates at 3
    v(4'b0001, 0, 0, 0, 2'b00, 2'd0, 2'd0);
    v(4'b0010, 0, 0, 0, 2'b00, 2'd0, 2'd1);
    v(4'b0100, 0, 1, 0, 2'b00, 2'd0, 2'd2);
    v(4'b1000, 0, 1, 0, 2'b00, 2'd0, 2'd3);
    v(4'b0001, 0, 1, 0, 2'b00, 2'd1, 2'd0);
    rev4(2'd1, 2'd2);
    rev4(2'd2, 2'd3);
    rev4(2'd3, 2'd3);
    rev4(2'd3, 2'd3);
    // All-zero while locked faults with not-one-hot code
    v(4'b0000, 0, 0, 1, 2'b01, 2'd3, 2'd0);

    @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    // Asynchronous reset mid-cycle clears outputs without a clock edge
    reset = 0;
    #1;
    check("async_reset", '0);
    #4;
    reset = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
